// File: rtl/rcu_pkg.sv
// rcu_pkg: run-control state encodings and breakpoint index width helper
package rcu_pkg;
    typedef enum logic [1:0] {HALT = 2'd0, RUN = 2'd1, STEP = 2'd2, BP_HALT = 2'd3} state_t;
    function automatic int bp_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/run_control_unit_btn_debounce.sv
// btn_debounce: 2-flop synchroniser, stable-level debouncer and one-cycle press pulse
module btn_debounce #(
    parameter int CYCLES = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_pulse
);
    localparam int CW = $clog2(CYCLES);
    logic [1:0]    sync;
    logic          level;
    logic [CW-1:0] cnt;
    logic          done;
    // a new level is accepted on the CYCLES-th consecutive differing sample
    assign done = (sync[1] != level) && (cnt == CW'(CYCLES - 1));
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            sync    <= '0;
            level   <= 1'b0;
            cnt     <= '0;
            o_pulse <= 1'b0;
        end else begin
            sync    <= {sync[0], i_btn};
            cnt     <= (sync[1] == level || done) ? '0 : cnt + 1'b1;
            level   <= done ? sync[1] : level;
            o_pulse <= done && sync[1];
        end
    end
endmodule

// File: rtl/run_control_unit.sv
// run_control_unit: pipeline clock enable with debounced run/step buttons,
// N-step mode, PC breakpoints with resume-skip and an enabled-cycle counter
module run_control_unit import rcu_pkg::*; #(
    parameter int PC_W            = 64,
    parameter int NUM_BP          = 4,
    parameter int STEP_W          = 16,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CYC_W           = 32,
    localparam int IW             = bp_idx_w(NUM_BP)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_btn_run,
    input  logic              i_btn_step,
    input  logic              i_mode_step_n,
    input  logic [STEP_W-1:0] i_step_count,
    input  logic              i_bp_wr_en,
    input  logic [IW-1:0]     i_bp_idx,
    input  logic [PC_W-1:0]   i_bp_addr,
    input  logic              i_bp_valid,
    input  logic [PC_W-1:0]   i_pc_f,
    output logic              o_clk_en,
    output logic [1:0]        o_state,
    output logic              o_bp_hit,
    output logic [IW-1:0]     o_bp_hit_idx,
    output logic [STEP_W-1:0] o_steps_left,
    output logic [CYC_W-1:0]  o_cycle_cnt
);
    state_t            state_q, state_d;
    logic [STEP_W-1:0] steps_q, steps_d, load;
    logic [IW-1:0]     hit_q, hit_d, match_idx;
    logic              skip_q, skip_d, any_match, bp_match, run_p, step_p;
    logic [CYC_W-1:0]  cyc_q;
    logic [PC_W-1:0]   bp_addr [NUM_BP];
    logic [NUM_BP-1:0] bp_vld;

    btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_run  (.i_clk(i_clk), .i_rst(i_rst), .i_btn(i_btn_run),  .o_pulse(run_p));
    btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_step (.i_clk(i_clk), .i_rst(i_rst), .i_btn(i_btn_step), .o_pulse(step_p));

    // out-of-range indices simply match no entry
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < NUM_BP; i++)
            if (i_bp_wr_en && i_bp_idx == IW'(i)) bp_addr[i] <= i_bp_addr;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) bp_vld <= '0;
        else
            for (int i = 0; i < NUM_BP; i++)
                if (i_bp_wr_en && i_bp_idx == IW'(i)) bp_vld[i] <= i_bp_valid;
    end

    always_comb begin
        any_match = 1'b0;
        match_idx = '0;
        for (int i = NUM_BP - 1; i >= 0; i--)
            if (bp_vld[i] && bp_addr[i] == i_pc_f) begin
                any_match = 1'b1;
                match_idx = IW'(i);
            end
    end

    assign bp_match = any_match && !skip_q;
    assign o_clk_en = (state_q == RUN || state_q == STEP) && !bp_match;
    assign load     = (i_mode_step_n && i_step_count != '0) ? i_step_count : STEP_W'(1);

    always_comb begin
        state_d = state_q;
        steps_d = steps_q;
        hit_d   = hit_q;
        skip_d  = o_clk_en ? 1'b0 : skip_q;
        case (state_q)
            HALT, BP_HALT: begin
                if (run_p) begin
                    state_d = RUN;
                    skip_d  = skip_q || state_q == BP_HALT;
                end else if (step_p) begin
                    state_d = STEP;
                    steps_d = load;
                    skip_d  = skip_q || state_q == BP_HALT;
                end
            end
            RUN: begin
                if (run_p) state_d = HALT;
                else if (bp_match) begin
                    state_d = BP_HALT;
                    hit_d   = match_idx;
                end
            end
            STEP: begin
                if (run_p) begin
                    state_d = HALT;
                    steps_d = '0;
                end else if (bp_match) begin
                    state_d = BP_HALT;
                    hit_d   = match_idx;
                end else begin
                    steps_d = steps_q - 1'b1;
                    state_d = (steps_q == STEP_W'(1)) ? HALT : STEP;
                end
            end
            default: state_d = HALT;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= HALT;
            steps_q <= '0;
            hit_q   <= '0;
            skip_q  <= 1'b0;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            steps_q <= steps_d;
            hit_q   <= hit_d;
            skip_q  <= skip_d;
            cyc_q   <= cyc_q + CYC_W'(o_clk_en);
        end
    end

    assign o_state      = state_q;
    assign o_bp_hit     = state_q == BP_HALT;
    assign o_bp_hit_idx = hit_q;
    assign o_steps_left = steps_q;
    assign o_cycle_cnt  = cyc_q;
endmodule

// File: tb/tb_run_control_unit.sv
// tb_run_control_unit: directed self-checking bench for run_control_unit
module tb_run_control_unit;
    logic        i_clk = 1'b0, i_rst = 1'b0;
    logic        i_btn_run = 1'b0, i_btn_step = 1'b0, i_mode_step_n = 1'b0;
    logic [15:0] i_step_count = 16'd0;
    logic        i_bp_wr_en = 1'b0, i_bp_valid = 1'b0;
    logic [1:0]  i_bp_idx = 2'd0;
    logic [63:0] i_bp_addr = 64'd0, i_pc_f = 64'd0;
    logic        o_clk_en, o_bp_hit, w_clk_en, w_bp_hit;
    logic [1:0]  o_state, o_bp_hit_idx, w_state, w_bp_hit_idx;
    logic [15:0] o_steps_left, w_steps_left;
    logic [31:0] o_cycle_cnt, c0;
    logic [3:0]  w_cycle_cnt;
    int n_checks = 0, n_fail = 0;

    run_control_unit #(.PC_W(64), .NUM_BP(4), .STEP_W(16), .DEBOUNCE_CYCLES(4), .CYC_W(32)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_btn_run(i_btn_run), .i_btn_step(i_btn_step),
        .i_mode_step_n(i_mode_step_n), .i_step_count(i_step_count), .i_bp_wr_en(i_bp_wr_en),
        .i_bp_idx(i_bp_idx), .i_bp_addr(i_bp_addr), .i_bp_valid(i_bp_valid), .i_pc_f(i_pc_f),
        .o_clk_en(o_clk_en), .o_state(o_state), .o_bp_hit(o_bp_hit), .o_bp_hit_idx(o_bp_hit_idx),
        .o_steps_left(o_steps_left), .o_cycle_cnt(o_cycle_cnt));

    run_control_unit #(.PC_W(64), .NUM_BP(4), .STEP_W(16), .DEBOUNCE_CYCLES(4), .CYC_W(4)) dut_w (
        .i_clk(i_clk), .i_rst(i_rst), .i_btn_run(i_btn_run), .i_btn_step(i_btn_step),
        .i_mode_step_n(i_mode_step_n), .i_step_count(i_step_count), .i_bp_wr_en(i_bp_wr_en),
        .i_bp_idx(i_bp_idx), .i_bp_addr(i_bp_addr), .i_bp_valid(i_bp_valid), .i_pc_f(i_pc_f),
        .o_clk_en(w_clk_en), .o_state(w_state), .o_bp_hit(w_bp_hit), .o_bp_hit_idx(w_bp_hit_idx),
        .o_steps_left(w_steps_left), .o_cycle_cnt(w_cycle_cnt));

    always #5 i_clk = ~i_clk;

    task automatic tick(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic bp_write(input logic [1:0] idx, input logic [63:0] addr, input logic vld);
        i_bp_wr_en = 1'b1; i_bp_idx = idx; i_bp_addr = addr; i_bp_valid = vld;
        tick(1);
        i_bp_wr_en = 1'b0;
    endtask

    task automatic release_btns;
        i_btn_run = 1'b0; i_btn_step = 1'b0;
        tick(8);
    endtask

    task automatic test_reset;
        tick(2);
        n_checks++; if (o_state !== 2'd0 || o_clk_en !== 1'b0) begin n_fail++; $display("FAIL reset_state: state %0d en %0d, expected 0 0", o_state, o_clk_en); end
        n_checks++; if (o_steps_left !== 16'd0 || o_cycle_cnt !== 32'd0 || o_bp_hit !== 1'b0 || o_bp_hit_idx !== 2'd0) begin n_fail++; $display("FAIL reset_outs: steps %0d cnt %0d hit %0d idx %0d, expected all 0", o_steps_left, o_cycle_cnt, o_bp_hit, o_bp_hit_idx); end
        i_rst = 1'b1;
        tick(1);
        n_checks++; if (o_state !== 2'd0) begin n_fail++; $display("FAIL reset_release_state: got %0d expected 0", o_state); end
    endtask

    task automatic test_run_bounce;
        i_btn_run = 1'b1; tick(2); i_btn_run = 1'b0; tick(2);
        i_btn_run = 1'b1; tick(2); i_btn_run = 1'b0; tick(1);
        i_btn_run = 1'b1;
        tick(6);
        n_checks++; if (o_state !== 2'd0) begin n_fail++; $display("FAIL bounce_early: state %0d expected 0", o_state); end
        tick(1);
        n_checks++; if (o_state !== 2'd1 || o_clk_en !== 1'b1) begin n_fail++; $display("FAIL bounce_run: state %0d en %0d, expected 1 1", o_state, o_clk_en); end
        release_btns();
        n_checks++; if (o_state !== 2'd1) begin n_fail++; $display("FAIL bounce_single_pulse: state %0d expected 1", o_state); end
        i_btn_run = 1'b1; tick(7);
        n_checks++; if (o_state !== 2'd0 || o_clk_en !== 1'b0) begin n_fail++; $display("FAIL run_halt: state %0d en %0d, expected 0 0", o_state, o_clk_en); end
        release_btns();
    endtask

    task automatic test_step_n;
        i_mode_step_n = 1'b1; i_step_count = 16'd5; c0 = o_cycle_cnt;
        i_btn_step = 1'b1;
        tick(7);
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (o_state !== 2'd2 || o_clk_en !== 1'b1 || o_steps_left !== 16'(5 - i)) begin n_fail++; $display("FAIL step5_cycle%0d: state %0d en %0d steps %0d, expected 2 1 %0d", i, o_state, o_clk_en, o_steps_left, 5 - i); end
            tick(1);
        end
        n_checks++; if (o_state !== 2'd0 || o_clk_en !== 1'b0 || o_steps_left !== 16'd0) begin n_fail++; $display("FAIL step5_done: state %0d en %0d steps %0d, expected 0 0 0", o_state, o_clk_en, o_steps_left); end
        n_checks++; if (o_cycle_cnt !== c0 + 32'd5) begin n_fail++; $display("FAIL step5_cnt: got %0d expected %0d", o_cycle_cnt, c0 + 32'd5); end
        release_btns();
    endtask

    task automatic test_breakpoint;
        bp_write(2'd2, 64'h80, 1'b1);
        bp_write(2'd1, 64'h80, 1'b1);
        i_pc_f = 64'h80; c0 = o_cycle_cnt;
        i_btn_run = 1'b1; tick(7);
        n_checks++; if (o_state !== 2'd1 || o_clk_en !== 1'b0) begin n_fail++; $display("FAIL bp_gate: state %0d en %0d, expected 1 0", o_state, o_clk_en); end
        tick(1);
        n_checks++; if (o_state !== 2'd3 || o_bp_hit !== 1'b1 || o_bp_hit_idx !== 2'd1 || o_clk_en !== 1'b0) begin n_fail++; $display("FAIL bp_halt: state %0d hit %0d idx %0d en %0d, expected 3 1 1 0", o_state, o_bp_hit, o_bp_hit_idx, o_clk_en); end
        n_checks++; if (o_cycle_cnt !== c0) begin n_fail++; $display("FAIL bp_cnt: got %0d expected %0d", o_cycle_cnt, c0); end
        release_btns();
        bp_write(2'd1, 64'h80, 1'b0);
        n_checks++; if (o_state !== 2'd3 || o_bp_hit !== 1'b1) begin n_fail++; $display("FAIL bp_clear_stays: state %0d hit %0d, expected 3 1", o_state, o_bp_hit); end
        i_btn_run = 1'b1; tick(7);
        n_checks++; if (o_state !== 2'd1 || o_clk_en !== 1'b1) begin n_fail++; $display("FAIL bp_skip: state %0d en %0d, expected 1 1", o_state, o_clk_en); end
        tick(1);
        n_checks++; if (o_state !== 2'd1 || o_clk_en !== 1'b0) begin n_fail++; $display("FAIL bp_skip_once: state %0d en %0d, expected 1 0", o_state, o_clk_en); end
        tick(1);
        n_checks++; if (o_state !== 2'd3 || o_bp_hit_idx !== 2'd2) begin n_fail++; $display("FAIL bp_rehit: state %0d idx %0d, expected 3 2", o_state, o_bp_hit_idx); end
        release_btns();
        i_pc_f = 64'h84;
        i_btn_run = 1'b1; tick(7);
        n_checks++; if (o_state !== 2'd1 || o_clk_en !== 1'b1) begin n_fail++; $display("FAIL bp_continue: state %0d en %0d, expected 1 1", o_state, o_clk_en); end
        release_btns();
        i_btn_run = 1'b1; tick(7); release_btns();
    endtask

    task automatic test_step_zero;
        i_mode_step_n = 1'b1; i_step_count = 16'd0; c0 = o_cycle_cnt;
        i_btn_step = 1'b1; tick(7);
        n_checks++; if (o_state !== 2'd2 || o_steps_left !== 16'd1 || o_clk_en !== 1'b1) begin n_fail++; $display("FAIL step0_start: state %0d steps %0d en %0d, expected 2 1 1", o_state, o_steps_left, o_clk_en); end
        tick(1);
        n_checks++; if (o_state !== 2'd0 || o_steps_left !== 16'd0 || o_cycle_cnt !== c0 + 32'd1) begin n_fail++; $display("FAIL step0_done: state %0d steps %0d cnt %0d, expected 0 0 %0d", o_state, o_steps_left, o_cycle_cnt, c0 + 32'd1); end
        release_btns();
    endtask

    task automatic test_back_to_back;
        i_btn_run = 1'b1; i_btn_step = 1'b1; tick(7);
        n_checks++; if (o_state !== 2'd1) begin n_fail++; $display("FAIL same_cycle_run_wins: state %0d expected 1", o_state); end
        release_btns();
        i_btn_run = 1'b1; tick(7); release_btns();
        i_step_count = 16'd10;
        i_btn_step = 1'b1; tick(8);
        i_btn_run = 1'b1; tick(6);
        n_checks++; if (o_state !== 2'd2 || o_steps_left !== 16'd3) begin n_fail++; $display("FAIL abort_pre: state %0d steps %0d, expected 2 3", o_state, o_steps_left); end
        tick(1);
        n_checks++; if (o_state !== 2'd0 || o_steps_left !== 16'd0) begin n_fail++; $display("FAIL abort_step: state %0d steps %0d, expected 0 0", o_state, o_steps_left); end
        release_btns();
    endtask

    task automatic test_async_reset;
        i_step_count = 16'd10;
        i_btn_step = 1'b1; tick(9);
        i_rst = 1'b0; i_btn_step = 1'b0;
        #1;
        n_checks++; if (o_state !== 2'd0 || o_clk_en !== 1'b0 || o_steps_left !== 16'd0 || o_cycle_cnt !== 32'd0 || o_bp_hit !== 1'b0 || o_bp_hit_idx !== 2'd0) begin n_fail++; $display("FAIL async_reset: state %0d en %0d steps %0d cnt %0d hit %0d idx %0d, expected all 0", o_state, o_clk_en, o_steps_left, o_cycle_cnt, o_bp_hit, o_bp_hit_idx); end
        tick(1);
        i_rst = 1'b1; i_pc_f = 64'h80;
        i_btn_run = 1'b1; tick(7);
        n_checks++; if (o_state !== 2'd1 || o_clk_en !== 1'b1) begin n_fail++; $display("FAIL bp_cleared_by_reset: state %0d en %0d, expected 1 1", o_state, o_clk_en); end
        tick(1);
        n_checks++; if (o_state !== 2'd1 || o_clk_en !== 1'b1) begin n_fail++; $display("FAIL bp_cleared_run: state %0d en %0d, expected 1 1", o_state, o_clk_en); end
        release_btns();
        i_btn_run = 1'b1; tick(7); release_btns();
    endtask

    task automatic test_cnt_wrap;
        i_rst = 1'b0; tick(1); i_rst = 1'b1; i_pc_f = 64'h84;
        i_btn_run = 1'b1; tick(7);
        n_checks++; if (w_state !== 2'd1 || w_cycle_cnt !== 4'd0) begin n_fail++; $display("FAIL wrap_start: state %0d cnt %0d, expected 1 0", w_state, w_cycle_cnt); end
        tick(15);
        n_checks++; if (w_cycle_cnt !== 4'd15 || o_cycle_cnt !== 32'd15) begin n_fail++; $display("FAIL wrap_allones: narrow %0d wide %0d, expected 15 15", w_cycle_cnt, o_cycle_cnt); end
        tick(1);
        n_checks++; if (w_cycle_cnt !== 4'd0 || o_cycle_cnt !== 32'd16) begin n_fail++; $display("FAIL wrap_zero: narrow %0d wide %0d, expected 0 16", w_cycle_cnt, o_cycle_cnt); end
        release_btns();
    endtask

    initial begin
        test_reset();
        test_run_bounce();
        test_step_n();
        test_breakpoint();
        test_step_zero();
        test_back_to_back();
        test_async_reset();
        test_cnt_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
